// File: rtl/wb_writeback_if.sv
// Bus between the MEM stage / data memory and the writeback unit.
// The master side drives instructions and load data. The slave side (the
// writeback unit) drives the register file write port, the timeout pulse and
// the retire counter.
interface wb_writeback_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rd;
    logic                 in_reg_write;
    logic                 in_mem_to_reg;
    logic [2:0]           in_funct3;
    logic [31:0]          in_alu_result;
    logic                 load_valid;
    logic [31:0]          load_data;
    logic                 reg_write;
    logic [4:0]           rd;
    logic [31:0]          write_back_data;
    logic                 load_timeout;
    logic [CNT_WIDTH-1:0] retire_count;

    modport master (
        output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_funct3,
               in_alu_result, load_valid, load_data,
        input  in_ready, reg_write, rd, write_back_data, load_timeout,
               retire_count
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_funct3,
               in_alu_result, load_valid, load_data,
        output in_ready, reg_write, rd, write_back_data, load_timeout,
               retire_count
    );
endinterface

// File: rtl/wb_writeback_unit.sv
// MEM/WB writeback stage. It accepts one retiring instruction per cycle and
// waits for load data when the result comes from memory. The load data is
// aligned and extended. The unit then presents one registered register-file
// write per instruction. All outputs are registered so that they are stable
// before the register file writes on the falling edge.
module wb_writeback_unit #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_writeback_if.slave wb
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t               state_q;
    logic [7:0]           tmo_cnt_q;
    logic [4:0]           lat_rd_q;
    logic                 lat_reg_write_q;
    logic [2:0]           lat_funct3_q;
    logic [1:0]           lat_offset_q;
    logic                 reg_write_q;
    logic [4:0]           rd_q;
    logic [31:0]          wb_data_q;
    logic                 load_timeout_q;
    logic [CNT_WIDTH-1:0] retire_count_q;
    logic                 xfer;

    // Load alignment. Misaligned halfwords use only offset[1].
    // Unknown funct3 values behave like LW.
    function automatic logic [31:0] align_load(input logic [31:0] data,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  offset);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        byte_v = data[{offset, 3'b000} +: 8];
        half_v = offset[1] ? data[31:16] : data[15:0];
        case (funct3)
            3'b000:  result = {{24{byte_v[7]}}, byte_v};
            3'b001:  result = {{16{half_v[15]}}, half_v};
            3'b100:  result = {24'd0, byte_v};
            3'b101:  result = {16'd0, half_v};
            default: result = data;
        endcase
        return result;
    endfunction

    assign wb.in_ready = (state_q == IDLE) || (state_q == WRITE);
    assign xfer        = wb.in_valid && wb.in_ready;

    // Control FSM plus all registered outputs. reg_write and load_timeout
    // default low, so each of them is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            tmo_cnt_q       <= 8'd0;
            lat_rd_q        <= 5'd0;
            lat_reg_write_q <= 1'b0;
            lat_funct3_q    <= 3'd0;
            lat_offset_q    <= 2'd0;
            reg_write_q     <= 1'b0;
            rd_q            <= 5'd0;
            wb_data_q       <= 32'd0;
            load_timeout_q  <= 1'b0;
            retire_count_q  <= '0;
        end else begin
            reg_write_q    <= 1'b0;
            load_timeout_q <= 1'b0;
            if (reg_write_q) begin
                retire_count_q <= retire_count_q + 1'b1;
            end
            case (state_q)
                IDLE, WRITE: begin
                    if (xfer) begin
                        lat_rd_q        <= wb.in_rd;
                        lat_reg_write_q <= wb.in_reg_write;
                        lat_funct3_q    <= wb.in_funct3;
                        lat_offset_q    <= wb.in_alu_result[1:0];
                        if (wb.in_mem_to_reg) begin
                            state_q   <= WAIT_LOAD;
                            tmo_cnt_q <= 8'd0;
                        end else begin
                            state_q     <= WRITE;
                            rd_q        <= wb.in_rd;
                            wb_data_q   <= wb.in_alu_result;
                            reg_write_q <= wb.in_reg_write && (wb.in_rd != 5'd0);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_LOAD: begin
                    if (wb.load_valid) begin
                        state_q     <= WRITE;
                        rd_q        <= lat_rd_q;
                        wb_data_q   <= align_load(wb.load_data, lat_funct3_q, lat_offset_q);
                        reg_write_q <= lat_reg_write_q && (lat_rd_q != 5'd0);
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q        <= IDLE;
                        load_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb.reg_write       = reg_write_q;
    assign wb.rd              = rd_q;
    assign wb.write_back_data = wb_data_q;
    assign wb.load_timeout    = load_timeout_q;
    assign wb.retire_count    = retire_count_q;
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit. It runs directed scenarios with
// literal expectations and then a randomized phase. A transaction-level
// reference model predicts every output, and one compare process checks the
// outputs on each falling edge.
module tb_wb_writeback_unit;
    localparam int LOAD_TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    wb_writeback_if #(.CNT_WIDTH(32)) bus();

    wb_writeback_unit #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result, computed with shifts and masks from the word.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int f3, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        h = (w >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            0:       return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            1:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    // Reference model: "busy" means waiting for load data.
    // "waited" counts the cycles that have passed without data.
    bit          m_busy;
    int          m_waited;
    logic [4:0]  m_rd;
    bit          m_rw;
    int          m_f3;
    int          m_off;
    bit          exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          exp_to;
    logic [31:0] exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_waited <= 0;
            m_rd     <= 5'd0;
            m_rw     <= 1'b0;
            m_f3     <= 0;
            m_off    <= 0;
            exp_rw   <= 1'b0;
            exp_rd   <= 5'd0;
            exp_data <= 32'd0;
            exp_to   <= 1'b0;
            exp_cnt  <= 32'd0;
        end else begin
            exp_rw <= 1'b0;
            exp_to <= 1'b0;
            if (exp_rw) exp_cnt <= exp_cnt + 32'd1;
            if (!m_busy) begin
                if (bus.in_valid) begin
                    if (bus.in_mem_to_reg) begin
                        m_busy   <= 1'b1;
                        m_waited <= 0;
                        m_rd     <= bus.in_rd;
                        m_rw     <= bus.in_reg_write;
                        m_f3     <= int'(bus.in_funct3);
                        m_off    <= int'(bus.in_alu_result % 4);
                    end else begin
                        exp_rw   <= bus.in_reg_write && (bus.in_rd != 5'd0);
                        exp_rd   <= bus.in_rd;
                        exp_data <= bus.in_alu_result;
                    end
                end
            end else if (bus.load_valid) begin
                m_busy   <= 1'b0;
                exp_rw   <= m_rw && (m_rd != 5'd0);
                exp_rd   <= m_rd;
                exp_data <= model_load(bus.load_data, m_f3, m_off);
            end else if (m_waited + 1 == LOAD_TIMEOUT) begin
                m_busy <= 1'b0;
                exp_to <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("in_ready",        32'(bus.in_ready),     32'(!m_busy));
        chk("reg_write",       32'(bus.reg_write),    32'(exp_rw));
        chk("rd",              32'(bus.rd),           32'(exp_rd));
        chk("write_back_data", bus.write_back_data,   exp_data);
        chk("load_timeout",    32'(bus.load_timeout), 32'(exp_to));
        chk("retire_count",    bus.retire_count,      exp_cnt);
        if (bus.reg_write)
            $display("write x%0d <= %h (retired=%0d)", bus.rd, bus.write_back_data, bus.retire_count);
        if (bus.load_timeout)
            $display("load abandoned at %0t", $time);
    end

    // Presents one instruction for one cycle. Returns on the falling edge
    // after the accepting rising edge.
    task automatic issue(input logic [4:0] rdv, input bit rw, input bit m2r,
                         input logic [2:0] f3, input logic [31:0] alu);
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.in_rd         = rdv;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = m2r;
        bus.in_funct3     = f3;
        bus.in_alu_result = alu;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Accept a load, supply data 3 cycles after accept, check the write a cycle later.
    task automatic directed_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] expect_data);
        issue(5'd7, 1'b1, 1'b1, f3, {30'd0, off});
        @(negedge clk);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h80FF_7F01;
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk({name, "_we"},   32'(bus.reg_write), 32'd1);
        chk({name, "_data"}, bus.write_back_data, expect_data);
    endtask

    initial begin
        bit seen;
        int cyc;
        int lv_pct;

        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_rd         = 5'd0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.in_funct3     = 3'd0;
        bus.in_alu_result = 32'd0;
        bus.load_valid    = 1'b0;
        bus.load_data     = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_count", bus.retire_count, 32'd0);
        chk("reset_data",  bus.write_back_data, 32'd0);

        // ALU write, latency one cycle
        issue(5'd5, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF);
        chk("alu_we",   32'(bus.reg_write), 32'd1);
        chk("alu_rd",   32'(bus.rd), 32'd5);
        chk("alu_data", bus.write_back_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("alu_pulse_end", 32'(bus.reg_write), 32'd0);
        chk("alu_count", bus.retire_count, 32'd1);

        // Loads: alignment and extension
        directed_load("lb_off1",  3'b000, 2'd1, 32'h0000_007F);
        directed_load("lbu_off2", 3'b100, 2'd2, 32'h0000_00FF);
        directed_load("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
        directed_load("lw",       3'b010, 2'd3, 32'h80FF_7F01);

        // x0 is never written
        issue(5'd0, 1'b1, 1'b0, 3'd0, 32'h1234_5678);
        chk("x0_we", 32'(bus.reg_write), 32'd0);
        chk("x0_data", bus.write_back_data, 32'h1234_5678);

        // Load timeout after LOAD_TIMEOUT cycles without data
        issue(5'd9, 1'b1, 1'b1, 3'b010, 32'd0);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 24 && !seen; i++) begin
            @(negedge clk);
            if (bus.load_timeout) begin
                seen = 1'b1;
                cyc  = i;
                chk("timeout_we",    32'(bus.reg_write), 32'd0);
                chk("timeout_ready", 32'(bus.in_ready), 32'd1);
            end
        end
        chk("timeout_seen",   32'(seen), 32'd1);
        chk("timeout_cycles", 32'(cyc), 32'd16);

        // Asynchronous reset in the middle of a load abandons it
        issue(5'd3, 1'b1, 1'b1, 3'b010, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_we",    32'(bus.reg_write), 32'd0);
        chk("areset_rd",    32'(bus.rd), 32'd0);
        chk("areset_data",  bus.write_back_data, 32'd0);
        chk("areset_count", bus.retire_count, 32'd0);
        chk("areset_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("areset_nowrite1", 32'(bus.reg_write), 32'd0);
        @(negedge clk);
        chk("areset_nowrite2", 32'(bus.reg_write), 32'd0);
        bus.load_valid = 1'b0;

        // Four back-to-back ALU instructions
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid      = 1'b1;
            bus.in_rd         = 5'(i);
            bus.in_reg_write  = 1'b1;
            bus.in_mem_to_reg = 1'b0;
            bus.in_alu_result = 32'(i * 32'h111);
            @(negedge clk);
            chk("b2b_we", 32'(bus.reg_write), 32'd1);
            chk("b2b_rd", 32'(bus.rd), 32'(i));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_count", bus.retire_count, 32'd4);

        // Randomized phase
        lv_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) lv_pct = (lv_pct == 30) ? 5 : 30;
            bus.in_valid      = ($urandom_range(0, 99) < 60);
            bus.in_rd         = 5'($urandom_range(0, 31));
            bus.in_reg_write  = ($urandom_range(0, 9) != 0);
            bus.in_mem_to_reg = ($urandom_range(0, 99) < 40);
            bus.in_funct3     = 3'($urandom_range(0, 7));
            bus.in_alu_result = $urandom;
            bus.load_valid    = ($urandom_range(0, 99) < lv_pct);
            bus.load_data     = $urandom;
            @(negedge clk);
        end
        bus.in_valid   = 1'b0;
        bus.load_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
